// File: rtl/mult_multicycle.sv
// Multi-cycle integer multiplier for the EX stage.
// Operands arrive from the forwarding muxes and are captured in the issue cycle.
// Upstream stages are frozen through a combinational stall request until the
// product is registered. LATENCY counts stall cycles, including the issue
// cycle, and must be in the range 2..8.
module mult_multicycle #(
    parameter int DATA_W  = 16,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              is_signed,
    input  logic              flush,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product_lo,
    output logic [DATA_W-1:0] product_hi
);

    localparam int CNT_W  = 4;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    // Operands latched at issue. Inputs are ignored after the issue cycle.
    typedef struct packed {
        logic              sgn;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    req_t                r_req;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_prod_lo;
    logic [DATA_W-1:0]   r_prod_hi;

    logic [PROD_W-1:0]   w_a_ext;
    logic [PROD_W-1:0]   w_b_ext;
    logic [PROD_W-1:0]   w_prod;
    logic                w_stall;

    // Extend both operands to full product width. The low PROD_W bits of the
    // product are then exact for both signed and unsigned modes.
    assign w_a_ext = {{DATA_W{r_req.sgn & r_req.a[DATA_W-1]}}, r_req.a};
    assign w_b_ext = {{DATA_W{r_req.sgn & r_req.b[DATA_W-1]}}, r_req.b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Stall request: raised in the issue cycle and through BUSY. A flush drops
    // it in the same cycle. It is held low while reset is asserted.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_stall = start & ~flush;
            S_BUSY:  w_stall = ~flush;
            default: w_stall = 1'b0;
        endcase
        if (!arst_n) w_stall = 1'b0;
    end

    // Control FSM with capture, countdown and product register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_req     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_prod_lo <= '0;
            r_prod_hi <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_req.sgn <= is_signed;
                        r_req.a   <= operand_a;
                        r_req.b   <= operand_b;
                        r_cnt     <= CNT_W'(LATENCY - 1);
                        r_state   <= S_BUSY;
                        r_busy    <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_prod_lo <= w_prod[DATA_W-1:0];
                            r_prod_hi <= w_prod[PROD_W-1:DATA_W];
                            r_state   <= S_DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end
                end
                // start in DONE still belongs to the retiring MUL, so it is ignored.
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign stall      = w_stall;
    assign busy       = r_busy;
    assign done       = r_done;
    assign product_lo = r_prod_lo;
    assign product_hi = r_prod_hi;

endmodule

// File: tb/tb_mult_multicycle.sv
// Directed bench for mult_multicycle. The main instance uses LATENCY=3, and a
// second instance uses LATENCY=2 for the back-to-back case.
module tb_mult_multicycle;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        start, is_signed, flush;
    logic [15:0] operand_a, operand_b;
    logic        stall, busy, done;
    logic [15:0] product_lo, product_hi;

    logic        d2_start, d2_is_signed, d2_flush;
    logic [15:0] d2_a, d2_b;
    logic        d2_stall, d2_busy, d2_done;
    logic [15:0] d2_lo, d2_hi;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mult_multicycle #(.DATA_W(16), .LATENCY(3)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .is_signed(is_signed),
        .flush(flush), .operand_a(operand_a), .operand_b(operand_b),
        .stall(stall), .busy(busy), .done(done),
        .product_lo(product_lo), .product_hi(product_hi)
    );

    mult_multicycle #(.DATA_W(16), .LATENCY(2)) dut2 (
        .clk(clk), .arst_n(arst_n), .start(d2_start), .is_signed(d2_is_signed),
        .flush(d2_flush), .operand_a(d2_a), .operand_b(d2_b),
        .stall(d2_stall), .busy(d2_busy), .done(d2_done),
        .product_lo(d2_lo), .product_hi(d2_hi)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full multiply on the main instance, with start issued in the current cycle.
    // The operand inputs are scrambled while BUSY, so only the captured copies
    // can yield the expected product.
    task automatic mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] ehi, input logic [15:0] elo);
        start = 1'b1; operand_a = a; operand_b = b; is_signed = s;
        #1;
        chk({tag, ".issue_stall"}, 32'(stall), 32'd1);
        chk({tag, ".issue_busy"},  32'(busy),  32'd0);
        step();
        start = 1'b0; operand_a = 16'h1234; operand_b = 16'h5678; is_signed = ~s;
        #1;
        chk({tag, ".b1_stall"}, 32'(stall), 32'd1);
        chk({tag, ".b1_busy"},  32'(busy),  32'd1);
        chk({tag, ".b1_done"},  32'(done),  32'd0);
        step();
        chk({tag, ".b2_stall"}, 32'(stall), 32'd1);
        chk({tag, ".b2_done"},  32'(done),  32'd0);
        step();
        chk({tag, ".done"},       32'(done),  32'd1);
        chk({tag, ".done_stall"}, 32'(stall), 32'd0);
        chk({tag, ".done_busy"},  32'(busy),  32'd0);
        chk({tag, ".prod"}, {product_hi, product_lo}, {ehi, elo});
        step();
        chk({tag, ".idle_done"}, 32'(done), 32'd0);
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        arst_n = 1'b0; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
        operand_a = '0; operand_b = '0;
        d2_start = 1'b0; d2_is_signed = 1'b0; d2_flush = 1'b0; d2_a = '0; d2_b = '0;
        #12;
        chk("rst.busy",  32'(busy),  32'd0);
        chk("rst.done",  32'(done),  32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.prod",  {product_hi, product_lo}, 32'h0);
        arst_n = 1'b1;
        step();

        mul("u3x5",     16'h0003, 16'h0005, 1'b0, 16'h0000, 16'h000F);
        mul("s_m2x7",   16'hFFFE, 16'h0007, 1'b1, 16'hFFFF, 16'hFFF2);
        mul("u_fffex7", 16'hFFFE, 16'h0007, 1'b0, 16'h0006, 16'hFFF2);
        mul("u10x10",   16'h0010, 16'h0010, 1'b0, 16'h0000, 16'h0100);
        mul("u_ffff2",  16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'h0001);
        mul("s_ffff2",  16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0001);
        mul("s_8000_2", 16'h8000, 16'h8000, 1'b1, 16'h4000, 16'h0000);

        // Flush in the second BUSY cycle
        start = 1'b1; operand_a = 16'h0003; operand_b = 16'h0003; is_signed = 1'b0;
        step();
        start = 1'b0;
        step();
        flush = 1'b1;
        #1;
        chk("fl.stall_drop", 32'(stall), 32'd0);
        chk("fl.busy_still", 32'(busy),  32'd1);
        step();
        flush = 1'b0;
        #1;
        chk("fl.idle_busy", 32'(busy), 32'd0);
        chk("fl.no_done",   32'(done), 32'd0);
        chk("fl.prod_hold", {product_hi, product_lo}, 32'h4000_0000);
        step();
        chk("fl.no_done2", 32'(done), 32'd0);

        // start and flush together in IDLE
        start = 1'b1; flush = 1'b1;
        #1;
        chk("sf.stall", 32'(stall), 32'd0);
        step();
        start = 1'b0; flush = 1'b0;
        #1;
        chk("sf.busy",  32'(busy),  32'd0);
        chk("sf.stall", 32'(stall), 32'd0);
        step();
        chk("sf.done", 32'(done), 32'd0);

        // Reset in the middle of BUSY
        start = 1'b1; operand_a = 16'h0005; operand_b = 16'h0005;
        step();
        arst_n = 1'b0;
        #1;
        chk("ar.busy",  32'(busy),  32'd0);
        chk("ar.done",  32'(done),  32'd0);
        chk("ar.stall", 32'(stall), 32'd0);
        chk("ar.prod",  {product_hi, product_lo}, 32'h0);
        start = 1'b0;
        #2;
        arst_n = 1'b1;
        step();
        chk("ar.post_busy", 32'(busy), 32'd0);
        step();
        chk("ar.post_done", 32'(done), 32'd0);
        step();
        chk("ar.post_done2", 32'(done), 32'd0);
        mul("post_rst", 16'h0003, 16'h0005, 1'b0, 16'h0000, 16'h000F);

        // LATENCY=2 instance with start held through DONE
        d2_start = 1'b1; d2_a = 16'h0003; d2_b = 16'h0005; d2_is_signed = 1'b0;
        #1;
        chk("bb.m1_issue_stall", 32'(d2_stall), 32'd1);
        step();
        chk("bb.m1_busy_stall", 32'(d2_stall), 32'd1);
        chk("bb.m1_busy",       32'(d2_busy),  32'd1);
        step();
        chk("bb.m1_done",  32'(d2_done),  32'd1);
        chk("bb.m1_stall", 32'(d2_stall), 32'd0);
        chk("bb.m1_prod",  {d2_hi, d2_lo}, 32'h0000_000F);
        d2_a = 16'h0002; d2_b = 16'h0004;
        step();
        chk("bb.m2_issue_stall", 32'(d2_stall), 32'd1);
        chk("bb.m2_issue_busy",  32'(d2_busy),  32'd0);
        chk("bb.m2_issue_done",  32'(d2_done),  32'd0);
        step();
        d2_start = 1'b0;
        #1;
        chk("bb.m2_busy_stall", 32'(d2_stall), 32'd1);
        step();
        chk("bb.m2_done",  32'(d2_done),  32'd1);
        chk("bb.m2_stall", 32'(d2_stall), 32'd0);
        chk("bb.m2_busy",  32'(d2_busy),  32'd0);
        chk("bb.m2_prod",  {d2_hi, d2_lo}, 32'h0000_0008);
        step();
        chk("bb.idle_done", 32'(d2_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
